// File: rtl/noc_from_merge.sv
// rtl/noc_from_merge.sv - two-port return-path merger forwarding whole packets round-robin
// Optional MERGE_OVF_DROP_PKT_EN: an overflowing packet is discarded instead of truncated.
module noc_from_merge #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p0_noc_from_dev_ctl,
  input  logic [7:0] p0_noc_from_dev_data,
  input  logic       p1_noc_from_dev_ctl,
  input  logic [7:0] p1_noc_from_dev_data,
  output logic       noc_from_dev_ctl,
  output logic [7:0] noc_from_dev_data,
  output logic [1:0] ovf,
  output logic       busy
);
  typedef enum logic {IDLE, SEND} state_t;

  logic [1:0]  in_ctl;
  logic [7:0]  in_data [2];
  logic [8:0]  mem [2][DEPTH];
  logic [AW:0] wptr [2], rptr [2], cnt [2], used [2];
  logic [AW:0] wptr_nx [2], cnt_nx [2];
  logic [1:0]  in_pkt, in_pkt_nx, ovf_nx, wr, pop, dec;
  logic [1:0]  is_cmd, is_nop, want, full;
`ifdef MERGE_OVF_DROP_PKT_EN
  logic [AW:0] mark [2], mark_nx [2];
`endif

  state_t      state, state_nx;
  logic        g, g_nx, rr, rr_nx;
  logic        out_ctl_nx;
  logic [7:0]  out_data_nx;
  logic [AW:0] used_g, rnext;
  logic [8:0]  head, next;
  logic        last, sending;

  assign in_ctl     = {p1_noc_from_dev_ctl, p0_noc_from_dev_ctl};
  assign in_data[0] = p0_noc_from_dev_data;
  assign in_data[1] = p1_noc_from_dev_data;

  assign sending = (state == SEND);
  assign busy    = sending;
  assign used_g  = wptr[g] - rptr[g];
  assign rnext   = rptr[g] + 1'b1;
  assign head    = mem[g][rptr[g][AW-1:0]];
  assign next    = mem[g][rnext[AW-1:0]];
  // Burst ends when the entry behind the head is absent or opens another packet.
  assign last    = (used_g <= (AW+1)'(1)) || next[8];
  assign pop[0]  = sending && !g && (used_g != '0);
  assign pop[1]  = sending &&  g && (used_g != '0);
  assign dec[0]  = sending && !g && last;
  assign dec[1]  = sending &&  g && last;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      used[p]      = wptr[p] - rptr[p];
      is_cmd[p]    = in_ctl[p] && (in_data[p] != 8'h00);
      is_nop[p]    = in_ctl[p] && (in_data[p] == 8'h00);
      want[p]      = in_pkt[p] ? !is_nop[p] : is_cmd[p];
      // A same-cycle pop frees a slot before the write lands.
      full[p]      = (used[p] == (AW+1)'(DEPTH)) && !pop[p];
      wr[p]        = want[p] && !full[p];
      in_pkt_nx[p] = is_cmd[p] ? 1'b1 : (is_nop[p] ? 1'b0 : in_pkt[p]);
      wptr_nx[p]   = wptr[p] + (AW+1)'(wr[p]);
      ovf_nx[p]    = ovf[p] || (want[p] && full[p]);
      cnt_nx[p]    = cnt[p] + (AW+1)'(in_pkt[p] && in_ctl[p]) - (AW+1)'(dec[p]);
`ifdef MERGE_OVF_DROP_PKT_EN
      mark_nx[p]   = is_cmd[p] ? wptr[p] : mark[p];
      if (want[p] && full[p]) begin
        in_pkt_nx[p] = 1'b0;
        wptr_nx[p]   = mark_nx[p];
      end
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    g_nx        = g;
    rr_nx       = rr;
    out_ctl_nx  = 1'b1;
    out_data_nx = 8'h00;
    case (state)
      IDLE: begin
        if ((cnt[0] != '0) || (cnt[1] != '0)) begin
          g_nx     = (cnt[rr] != '0) ? rr : !rr;
          rr_nx    = !g_nx;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (used_g != '0) {out_ctl_nx, out_data_nx} = head;
        if (last) begin
          state_nx = IDLE;
          // Back-to-back grant favours the other port so neither is served twice in a row.
          if ((cnt_nx[0] != '0) || (cnt_nx[1] != '0)) begin
            g_nx     = (cnt_nx[!g] != '0) ? !g : g;
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      g                 <= 1'b0;
      rr                <= 1'b0;
      noc_from_dev_ctl  <= 1'b1;
      noc_from_dev_data <= 8'h00;
      ovf               <= 2'b00;
      in_pkt            <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        cnt[p]  <= '0;
`ifdef MERGE_OVF_DROP_PKT_EN
        mark[p] <= '0;
`endif
      end
    end else begin
      state             <= state_nx;
      g                 <= g_nx;
      rr                <= rr_nx;
      noc_from_dev_ctl  <= out_ctl_nx;
      noc_from_dev_data <= out_data_nx;
      ovf               <= ovf_nx;
      in_pkt            <= in_pkt_nx;
      for (int p = 0; p < 2; p++) begin
        wptr[p] <= wptr_nx[p];
        rptr[p] <= rptr[p] + (AW+1)'(pop[p]);
        cnt[p]  <= cnt_nx[p];
`ifdef MERGE_OVF_DROP_PKT_EN
        mark[p] <= mark_nx[p];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr[p]) mem[p][wptr[p][AW-1:0]] <= {in_ctl[p], in_data[p]};
    end
  end
endmodule

// File: tb/tb_noc_from_merge.sv
// tb/tb_noc_from_merge.sv - directed self-checking bench for noc_from_merge
`timescale 1ns/1ps
module tb_noc_from_merge;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a0c, a1c, b0c, b1c;
  logic [7:0] a0d, a1d, b0d, b1d;
  logic       ac, bc, abusy, bbusy;
  logic [7:0] ad, bd;
  logic [1:0] aovf, bovf;
  logic [4:0] occ;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  noc_from_merge #(.DEPTH(16)) dut (
    .clk(clk), .reset(rst_n),
    .p0_noc_from_dev_ctl(a0c), .p0_noc_from_dev_data(a0d),
    .p1_noc_from_dev_ctl(a1c), .p1_noc_from_dev_data(a1d),
    .noc_from_dev_ctl(ac), .noc_from_dev_data(ad), .ovf(aovf), .busy(abusy)
  );

  noc_from_merge #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_n),
    .p0_noc_from_dev_ctl(b0c), .p0_noc_from_dev_data(b0d),
    .p1_noc_from_dev_ctl(b1c), .p1_noc_from_dev_data(b1d),
    .noc_from_dev_ctl(bc), .noc_from_dev_data(bd), .ovf(bovf), .busy(bbusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {busy, ctl, data} of the 16-deep instance
  task automatic chk_a(input string tag, input logic b, input logic c, input logic [7:0] d);
    chk(tag, {6'b0, abusy, ac, ad}, {6'b0, b, c, d});
  endtask

  task automatic chk_b(input string tag, input logic b, input logic c, input logic [7:0] d);
    chk(tag, {6'b0, bbusy, bc, bd}, {6'b0, b, c, d});
  endtask

  task automatic p0(input logic c, input logic [7:0] d); a0c = c; a0d = d; endtask
  task automatic p1(input logic c, input logic [7:0] d); a1c = c; a1d = d; endtask
  task automatic q0(input logic c, input logic [7:0] d); b0c = c; b0d = d; endtask

  initial begin
    rst_n = 1'b0;
    p0(1'b1, 8'h00); p1(1'b1, 8'h00); q0(1'b1, 8'h00);
    b1c = 1'b1; b1d = 8'h00;
    tick(); tick();
    chk_a("reset_out", 1'b0, 1'b1, 8'h00);
    chk("reset_ovf", {14'b0, aovf}, 16'h0);
    chk_b("reset_out4", 1'b0, 1'b1, 8'h00);
    rst_n = 1'b1;
    tick();

    // single packet on port 0
    p0(1'b1, 8'h23); tick();
    p0(1'b0, 8'hA1); tick();
    p0(1'b0, 8'hA2); tick();
    p0(1'b1, 8'h00); tick();
    chk_a("single_term", 1'b0, 1'b1, 8'h00);
    tick(); chk_a("single_grant", 1'b1, 1'b1, 8'h00);
    tick(); chk_a("single_cmd",   1'b1, 1'b1, 8'h23);
    tick(); chk_a("single_a1",    1'b1, 1'b0, 8'hA1);
    tick(); chk_a("single_a2",    1'b0, 1'b0, 8'hA2);
    tick(); chk_a("single_end",   1'b0, 1'b1, 8'h00);

    // simultaneous completion after reset
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    p0(1'b1, 8'h11); p1(1'b1, 8'h22); tick();
    p0(1'b0, 8'hB1); p1(1'b0, 8'hC1); tick();
    p0(1'b0, 8'hB2); p1(1'b0, 8'hC2); tick();
    p0(1'b1, 8'h00); p1(1'b1, 8'h00); tick();
    tick(); chk_a("tie_grant", 1'b1, 1'b1, 8'h00);
    tick(); chk_a("tie_p0cmd", 1'b1, 1'b1, 8'h11);
    tick(); chk_a("tie_b1",    1'b1, 1'b0, 8'hB1);
    tick(); chk_a("tie_b2",    1'b1, 1'b0, 8'hB2);
    tick(); chk_a("tie_p1cmd", 1'b1, 1'b1, 8'h22);
    tick(); chk_a("tie_c1",    1'b1, 1'b0, 8'hC1);
    tick(); chk_a("tie_c2",    1'b0, 1'b0, 8'hC2);
    tick(); chk_a("tie_end",   1'b0, 1'b1, 8'h00);

    // second tie: port 1 now goes first
    p0(1'b1, 8'h13); p1(1'b1, 8'h24); tick();
    p0(1'b0, 8'hD1); p1(1'b0, 8'hE1); tick();
    p0(1'b1, 8'h00); p1(1'b1, 8'h00); tick();
    tick(); chk_a("tie2_grant", 1'b1, 1'b1, 8'h00);
    tick(); chk_a("tie2_p1cmd", 1'b1, 1'b1, 8'h24);
    tick(); chk_a("tie2_e1",    1'b1, 1'b0, 8'hE1);
    tick(); chk_a("tie2_p0cmd", 1'b1, 1'b1, 8'h13);
    tick(); chk_a("tie2_d1",    1'b0, 1'b0, 8'hD1);
    tick(); chk_a("tie2_end",   1'b0, 1'b1, 8'h00);

    // back-to-back commands on port 1
    p1(1'b1, 8'h30); tick();
    p1(1'b0, 8'h01); tick();
    p1(1'b1, 8'h31); tick();
    chk("b2b_cnt1", {11'b0, dut.cnt[1]}, 16'd1);
    p1(1'b0, 8'h02); tick();
    chk_a("b2b_grant", 1'b1, 1'b1, 8'h00);
    p1(1'b1, 8'h00); tick();
    chk("b2b_cnt_peak", {11'b0, dut.cnt[1]}, 16'd2);
    chk_a("b2b_cmd30", 1'b1, 1'b1, 8'h30);
    tick(); chk_a("b2b_01", 1'b1, 1'b0, 8'h01);
    chk("b2b_cnt_mid", {11'b0, dut.cnt[1]}, 16'd1);
    tick(); chk_a("b2b_cmd31", 1'b1, 1'b1, 8'h31);
    tick(); chk_a("b2b_02", 1'b0, 1'b0, 8'h02);
    chk("b2b_cnt_end", {11'b0, dut.cnt[1]}, 16'd0);
    tick(); chk_a("b2b_end", 1'b0, 1'b1, 8'h00);

    // stray payload and idle NOPs
    p0(1'b0, 8'h55); tick(); tick();
    p0(1'b1, 8'h00); tick(); tick();
    chk_a("stray_out", 1'b0, 1'b1, 8'h00);
    occ = dut.wptr[0] - dut.rptr[0];
    chk("stray_occ", {11'b0, occ}, 16'd0);
    chk("stray_ovf", {14'b0, aovf}, 16'h0);

    // overflow on the 4-deep instance
    q0(1'b1, 8'h50); tick();
    q0(1'b0, 8'h51); tick();
    q0(1'b0, 8'h52); tick();
    q0(1'b0, 8'h53); tick();
    q0(1'b0, 8'h54); tick();
    chk("ovf_flag", {14'b0, bovf}, 16'h1);
    q0(1'b0, 8'h55); tick();
    q0(1'b1, 8'h00); tick();
`ifdef MERGE_OVF_DROP_PKT_EN
    for (int i = 0; i < 6; i++) begin
      tick(); chk_b("ovf_dropped", 1'b0, 1'b1, 8'h00);
    end
`else
    tick(); chk_b("ovf_grant", 1'b1, 1'b1, 8'h00);
    tick(); chk_b("ovf_cmd",   1'b1, 1'b1, 8'h50);
    tick(); chk_b("ovf_51",    1'b1, 1'b0, 8'h51);
    tick(); chk_b("ovf_52",    1'b1, 1'b0, 8'h52);
    tick(); chk_b("ovf_53",    1'b0, 1'b0, 8'h53);
    tick(); chk_b("ovf_end",   1'b0, 1'b1, 8'h00);
`endif
    q0(1'b1, 8'h5A); tick();
    q0(1'b0, 8'h5B); tick();
    q0(1'b1, 8'h00); tick();
    tick(); chk_b("after_grant", 1'b1, 1'b1, 8'h00);
    tick(); chk_b("after_cmd",   1'b1, 1'b1, 8'h5A);
    tick(); chk_b("after_5b",    1'b0, 1'b0, 8'h5B);
    tick(); chk_b("after_end",   1'b0, 1'b1, 8'h00);
    chk("ovf_sticky", {14'b0, bovf}, 16'h1);

    // reset during the second payload byte of a 6-byte packet
    p0(1'b1, 8'h61); tick();
    for (int d = 'h62; d <= 'h66; d++) begin
      p0(1'b0, 8'(d)); tick();
    end
    p0(1'b1, 8'h00); tick();
    tick(); tick();
    chk_a("rst_cmd", 1'b1, 1'b1, 8'h61);
    tick(); chk_a("rst_p1", 1'b1, 1'b0, 8'h62);
    tick(); chk_a("rst_p2", 1'b1, 1'b0, 8'h63);
    rst_n = 1'b0;
    #1;
    chk_a("rst_async_out", 1'b0, 1'b1, 8'h00);
    occ = dut.wptr[0] - dut.rptr[0];
    chk("rst_occ", {11'b0, occ}, 16'd0);
    chk("rst_ovf4", {14'b0, bovf}, 16'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); chk_a("rst_no_resend", 1'b0, 1'b1, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_from_merge.md
Name: noc_from_merge

Overview:
- Return-path merger for the NOC switch.
- Collects the device-to-NOC byte streams of two boxes (device 40 on port 0, device 41 on port 1) and buffers each in its own FIFO.
- Forwards only complete packets onto the single upstream from-interface, with round-robin arbitration.
- Each forwarded packet is sent as one contiguous, uninterleaved burst.

Parameters:
- DEPTH, 16, entries per port FIFO (power of 2, >=4). Maximum storable packet length is DEPTH bytes including the command byte.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- p0_noc_from_dev_ctl  input  1  port 0 (device 40) ctl.
- p0_noc_from_dev_data  input  8  port 0 data.
- p1_noc_from_dev_ctl  input  1  port 1 (device 41) ctl.
- p1_noc_from_dev_data  input  8  port 1 data.
- noc_from_dev_ctl  output  1  merged upstream ctl, registered.
- noc_from_dev_data  output  8  merged upstream data, registered.
- ovf  output  2  sticky per-port overflow flag.
- busy  output  1  high while a packet burst is being forwarded.

Behaviour:
- Protocol framing:
  - NOP = ctl=1, data=8'h00.
  - Command byte = ctl=1, data!=0; it opens a packet.
  - Payload bytes = ctl=0.
  - A packet ends at the next ctl=1 byte, which is either a NOP or the next command.
- Reset (reset=0, async):
  - FIFOs emptied.
  - Per-port in_pkt flags, complete-packet counters and rr pointer cleared; rr pointer = port 0 has priority first.
  - noc_from_dev_ctl=1, noc_from_dev_data=0.
  - ovf=0, busy=0.
  - Reset asserted mid-burst aborts the burst; output is NOP from the reset edge.
- Input side, per port, every cycle:
  - in_pkt=0 and NOP: ignored, not stored.
  - in_pkt=0 and ctl=0 (stray payload): dropped silently.
  - in_pkt=0 and command byte: written to FIFO; in_pkt=1.
  - in_pkt=1 and ctl=0: written.
  - in_pkt=1 and NOP: not written; cnt+=1; in_pkt=0.
  - in_pkt=1 and command byte: written; cnt+=1 for the finished packet; in_pkt stays 1.
  - cnt width is AW+1. A same-cycle increment and decrement nets to zero.
- FIFO full on a write: byte dropped and ovf[p] set until reset. Default framing state is unchanged; see Optional Feature.
- Output FSM states:
  - IDLE:
    - Output NOP.
    - If any cnt>0, grant the rr-preferred port when its cnt>0, otherwise the other port; go to SEND.
    - rr pointer flips to the non-granted port at grant.
  - SEND:
    - Each cycle, pop the granted FIFO head into the output register.
    - The first pop is the command byte. Continue while the next head is ctl=0 and the FIFO is non-empty.
    - On the last payload pop, decrement cnt[g].
    - Next state: if any cnt>0 after that update, grant immediately (back-to-back, no NOP gap). Otherwise go to IDLE.
- busy=1 in SEND.
- Latency: a complete packet whose terminator is sampled at edge N puts its command byte on the output at edge N+2 at the earliest, when IDLE.
- Simultaneous completion on both ports: the rr pointer decides. Neither port is granted twice in a row while the other has cnt>0.
- A packet of a single command byte with no payload is forwarded as 1 byte.
- Input writes and output pops on the same FIFO in the same cycle are both honoured, including when full at the write, because the pop frees space first.

Optional Feature:
- Macro: MERGE_OVF_DROP_PKT_EN.
- Defined:
  - Each port records the write pointer at the packet's command byte.
  - On overflow, the write pointer rewinds to that mark, discarding the partial packet.
  - in_pkt clears and further bytes are ignored until the next command byte.
  - ovf[p] still sets. No partial packet ever reaches the output.
- Undefined:
  - Only the overflowing byte is dropped. The truncated packet is still forwarded when terminated.

Test Plan:
- Single packet: port 0 sends cmd 8'h23, payload 8'hA1, 8'hA2, then NOP; port 1 idle. Output shows NOP, then 8'h23/ctl1, A1/ctl0, A2/ctl0, then NOP; busy high for 3 cycles.
- Simultaneous completion: both ports finish 3-byte packets (port 0 cmd 8'h11, port 1 cmd 8'h22) on the same edge after reset. Port 0 burst then port 1 burst back-to-back with no NOP gap. The next tie goes to port 1 first.
- Back-to-back commands: port 1 sends cmd 8'h30, 8'h01, cmd 8'h31, 8'h02, NOP. Two packets are forwarded in order; cnt[1] peaks at 2 and ends at 0.
- Stray and idle bytes: port 0 drives ctl0 data 8'h55 with in_pkt=0, and NOPs. Output stays NOP, no FIFO write, ovf=0.
- Overflow with DEPTH=4: port 0 sends cmd plus 5 payload bytes, then NOP. ovf[0]=1.
  - Macro undefined: a 4-byte truncated packet is forwarded.
  - Macro defined: nothing is forwarded and the next packet on port 0 passes intact.
- Reset mid-burst: assert reset=0 during the second payload byte of a 6-byte packet. Output is NOP immediately, FIFOs are empty, and the packet is not resent after release.
